// File: rtl/serial_config_engine.sv
// Serialises a flat configuration vector onto the chip's config chain,
// reading the previous chain contents back to detect upsets.
module serial_config_engine #(
    parameter int NUM_REGS   = 12,
    parameter int REG_W      = 8,
    parameter int CLK_DIV    = 4,
    parameter int RST_CYC    = 4,
    parameter int CAPT_CYC   = 2,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                      clkin,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      reset_en,
    input  logic [NUM_REGS*REG_W-1:0] cfg_data,
    input  logic                      sdo_in,
    output logic                      p_sck,
    output logic                      p_sda,
    output logic                      p_scapt,
    output logic                      p_reset,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_REGS*REG_W-1:0] readback,
    output logic                      mismatch
);

    localparam int N    = NUM_REGS * REG_W;
    localparam int BW   = $clog2(N + 1);
    localparam int DW   = $clog2(CLK_DIV + 1);
    localparam int PMAX = (RST_CYC > CAPT_CYC) ? RST_CYC : CAPT_CYC;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] RST_LAST  = PW'(RST_CYC - 1);
    localparam logic [PW-1:0] CAPT_LAST = PW'(CAPT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_CAPTURE,
        S_FIN
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [N-1:0]   new_snap_q, new_snap_d;
    logic [N-1:0]   snap_q, snap_d;
    logic [N-1:0]   rb_q, rb_d;
    logic           ren_q, ren_d;
    logic           prev_valid_q, prev_valid_d;
    logic           mismatch_q, mismatch_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [DW-1:0]  div_q, div_d;
    logic [PW-1:0]  ph_q, ph_d;
    logic           trig;

    // Only a pulse or an unprogrammed difference starts a transfer
    assign trig = start | (AUTO_START && (cfg_data != snap_q));

    // Outputs decode straight from the state so reset forces them low at once
    assign p_reset  = (state_q == S_RESET);
    assign p_sck    = (state_q == S_SHIFT_HI);
    assign p_scapt  = (state_q == S_CAPTURE);
    assign p_sda    = ((state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI))
                      & sr_q[N-1];
    assign busy     = p_reset | p_scapt
                      | (state_q == S_SHIFT_LO) | (state_q == S_SHIFT_HI);
    assign done     = (state_q == S_FIN);
    assign readback = rb_q;
    assign mismatch = mismatch_q;

    // Next-state and datapath updates for the transfer sequencer
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        new_snap_d   = new_snap_q;
        snap_d       = snap_q;
        rb_d         = rb_q;
        ren_d        = ren_q;
        prev_valid_d = prev_valid_q;
        mismatch_d   = mismatch_q;
        bit_d        = bit_q;
        div_d        = div_q;
        ph_d         = ph_q;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    sr_d       = cfg_data;
                    new_snap_d = cfg_data;
                    ren_d      = reset_en;
                    bit_d      = '0;
                    div_d      = '0;
                    ph_d       = '0;
                    state_d    = reset_en ? S_RESET : S_SHIFT_LO;
                end
            end
            S_RESET: begin
                if (ph_q == RST_LAST) begin
                    ph_d    = '0;
                    state_d = S_SHIFT_LO;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_SHIFT_LO: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (div_q == '0) begin
                    rb_d = {rb_q[N-2:0], sdo_in};
                end
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sr_d    = {sr_q[N-2:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == BIT_LAST) ? S_CAPTURE : S_SHIFT_LO;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (ph_q == CAPT_LAST) begin
                    ph_d    = '0;
                    state_d = S_FIN;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_FIN: begin
                mismatch_d   = prev_valid_q & ~ren_q & (rb_q != snap_q);
                snap_d       = new_snap_q;
                prev_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            new_snap_q   <= '0;
            snap_q       <= '0;
            rb_q         <= '0;
            ren_q        <= 1'b0;
            prev_valid_q <= 1'b0;
            mismatch_q   <= 1'b0;
            bit_q        <= '0;
            div_q        <= '0;
            ph_q         <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            new_snap_q   <= new_snap_d;
            snap_q       <= snap_d;
            rb_q         <= rb_d;
            ren_q        <= ren_d;
            prev_valid_q <= prev_valid_d;
            mismatch_q   <= mismatch_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            ph_q         <= ph_d;
        end
    end

endmodule

// File: tb/tb_serial_config_engine.sv
// Bench for serial_config_engine: a 16-bit chain model on sdo_in and a
// transfer-level reference for framing, bit order, readback and mismatch.
module tb_serial_config_engine;

    localparam int CD   = 2;
    localparam int RC   = 4;
    localparam int CC   = 2;
    localparam int NB   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        reset_en = 1'b0;
    logic [15:0] cfg_data = 16'h0;
    logic        sdo_in;
    logic        p_sck, p_sda, p_scapt, p_reset, busy, done, mismatch;
    logic [15:0] readback;

    logic        start6 = 1'b0;
    logic        ren6 = 1'b0;
    logic [15:0] cfg6 = 16'hBEEF;
    logic        sdo6 = 1'b0;
    logic        sck6, sda6, scapt6, reset6, busy6, done6, mm6;
    logic [15:0] rb6;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic        m_prev = 1'b0;
    logic [15:0] m_snap = 16'h0;

    logic [15:0] chip = 16'h0;
    logic        pend = 1'b0;
    logic        sck_prev = 1'b0;
    logic [15:0] flip_mask = 16'h0;
    logic        flip_tgl = 1'b0;
    logic        flip_seen = 1'b0;

    always #5 clk = ~clk;

    serial_config_engine #(
        .NUM_REGS(2), .REG_W(8), .CLK_DIV(CD), .RST_CYC(RC),
        .CAPT_CYC(CC), .AUTO_START(1'b1)
    ) dut (
        .clkin(clk), .rst_n(rst_n), .start(start), .reset_en(reset_en),
        .cfg_data(cfg_data), .sdo_in(sdo_in), .p_sck(p_sck), .p_sda(p_sda),
        .p_scapt(p_scapt), .p_reset(p_reset), .busy(busy), .done(done),
        .readback(readback), .mismatch(mismatch)
    );

    serial_config_engine #(
        .NUM_REGS(2), .REG_W(8), .CLK_DIV(1), .RST_CYC(1),
        .CAPT_CYC(1), .AUTO_START(1'b0)
    ) dut6 (
        .clkin(clk), .rst_n(rst_n), .start(start6), .reset_en(ren6),
        .cfg_data(cfg6), .sdo_in(sdo6), .p_sck(sck6), .p_sda(sda6),
        .p_scapt(scapt6), .p_reset(reset6), .busy(busy6), .done(done6),
        .readback(rb6), .mismatch(mm6)
    );

    // Chip chain: latches sda on sck rise, shifts on sck fall, clears on reset
    assign sdo_in = chip[15];
    always @(negedge clk) begin
        if (flip_tgl != flip_seen) begin
            chip      <= chip ^ flip_mask;
            flip_seen <= flip_tgl;
        end
        if (p_reset) chip <= 16'h0;
        if (p_sck && !sck_prev) pend <= p_sda;
        if (!p_sck && sck_prev) chip <= {chip[14:0], pend};
        sck_prev <= p_sck;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watches one whole transfer and compares it with the reference
    task automatic observe(input string tag, input logic [15:0] c_lat,
                           input logic ren, input int chg_at,
                           input logic [15:0] c2, input bit hold);
        int w, busy_n, rst_c, capt_c, rises, hi_c, perr;
        logic [15:0] seq, exp_rb;
        logic exp_mm, last_bit, sck_p;
        w = 0;
        while (busy !== 1'b1 && w < 4) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_busy_seen"}, 32'(busy), 32'd1);
        exp_rb = ren ? 16'h0 : chip;
        busy_n = 0; rst_c = 0; capt_c = 0; rises = 0; hi_c = 0; perr = 0;
        seq = 16'h0; last_bit = 1'b0; sck_p = 1'b0;
        while (busy === 1'b1 && busy_n < 4000) begin
            busy_n++;
            if (busy_n == chg_at) cfg_data = c2;
            rst_c  += int'(p_reset);
            capt_c += int'(p_scapt);
            hi_c   += int'(p_sck);
            if ((int'(p_sck) + int'(p_reset) + int'(p_scapt)) > 1) perr++;
            if (p_sck && !sck_p) begin
                seq = {seq[14:0], p_sda};
                rises++;
                last_bit = p_sda;
            end else if (p_sck && p_sda !== last_bit) begin
                perr++;
            end
            if ((p_scapt || p_reset) && p_sda) perr++;
            sck_p = p_sck;
            @(negedge clk);
        end
        if (hold) start = 1'b0;
        chk({tag, "_busy_len"}, 32'(busy_n),
            32'(RC * int'(ren) + 2 * CD * NB + CC));
        chk({tag, "_reset_cyc"}, 32'(rst_c), 32'(RC * int'(ren)));
        chk({tag, "_capt_cyc"}, 32'(capt_c), 32'(CC));
        chk({tag, "_sck_pulses"}, 32'(rises), 32'(NB));
        chk({tag, "_sck_high"}, 32'(hi_c), 32'(CD * NB));
        chk({tag, "_sda_seq"}, 32'(seq), 32'(c_lat));
        chk({tag, "_protocol"}, 32'(perr), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        exp_mm = m_prev & ~ren & (exp_rb != m_snap);
        m_snap = c_lat;
        m_prev = 1'b1;
        @(negedge clk);
        chk({tag, "_readback"}, 32'(readback), 32'(exp_rb));
        chk({tag, "_mismatch"}, 32'(mismatch), 32'(exp_mm));
        chk({tag, "_done_once"}, 32'(done), 32'd0);
        chk({tag, "_chip"}, 32'(chip), 32'(c_lat));
    endtask

    task automatic xfer(input string tag, input logic [15:0] c,
                        input logic ren, input bit use_start, input bit hold);
        cfg_data = c;
        reset_en = ren;
        start    = use_start;
        @(negedge clk);
        if (!hold) start = 1'b0;
        observe(tag, c, ren, 0, 16'h0, hold);
    endtask

    initial begin
        logic [15:0] rv;
        logic rr;
        int d0, idle_busy, guard, rises, n6, r6;
        logic sck_p;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", 32'({p_sck, p_sda, p_scapt, p_reset, done}), 32'd0);
        chk("rst_readback", 32'(readback), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", 32'(busy), 32'd0);

        xfer("t1", 16'hA5C3, 1'b1, 1'b1, 1'b0);

        xfer("t2a", 16'h1234, 1'b1, 1'b1, 1'b0);
        xfer("t2b", 16'h1234, 1'b0, 1'b1, 1'b0);
        chk("t2b_rb_const", 32'(readback), 32'h1234);
        flip_mask = 16'h0002;
        flip_tgl  = ~flip_tgl;
        repeat (2) @(negedge clk);
        xfer("t2c", 16'h1234, 1'b0, 1'b1, 1'b0);
        chk("t2c_rb_const", 32'(readback), 32'h1236);
        chk("t2c_mm_const", 32'(mismatch), 32'd1);

        xfer("t3z", 16'h0000, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        cfg_data = 16'h00FF;
        @(negedge clk);
        chk("t3_auto_latency", 32'(busy), 32'd1);
        observe("t3a", 16'h00FF, 1'b1, 10, 16'h0F0F, 1'b0);
        observe("t3b", 16'h0F0F, 1'b1, 0, 16'h0, 1'b0);

        d0 = done_cnt;
        xfer("t4", 16'h0F0F, 1'b0, 1'b1, 1'b1);
        idle_busy = 0;
        repeat (4) begin
            @(negedge clk);
            idle_busy += int'(busy);
        end
        chk("t4_no_requeue", 32'(idle_busy), 32'd0);
        chk("t4_done_count", 32'(done_cnt - d0), 32'd1);

        for (int i = 0; i < 6; i++) begin
            rv = 16'($urandom);
            rr = 1'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                flip_mask = 16'(1) << $urandom_range(15, 0);
                flip_tgl  = ~flip_tgl;
                repeat (2) @(negedge clk);
            end
            xfer($sformatf("rnd%0d", i), rv, rr, 1'b1, 1'b0);
        end

        cfg_data = 16'($urandom) | 16'h0100;
        reset_en = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0; guard = 0; sck_p = 1'b0;
        while (guard < 2000) begin
            if (p_sck === 1'b1 && sck_p === 1'b0) begin
                rises++;
                if (rises == 8) break;
            end
            sck_p = p_sck;
            @(negedge clk);
            guard++;
        end
        chk("t5_reached_bit7", 32'(rises), 32'd8);
        #2;
        rst_n    = 1'b0;
        cfg_data = 16'h0;
        #1;
        chk("t5_sck_drop", 32'(p_sck), 32'd0);
        chk("t5_sda_drop", 32'(p_sda), 32'd0);
        chk("t5_busy_drop", 32'(busy), 32'd0);
        m_prev = 1'b0;
        m_snap = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_busy = 0;
        repeat (3) begin
            @(negedge clk);
            idle_busy += int'(busy);
        end
        chk("t5_idle", 32'(idle_busy), 32'd0);
        chk("t5_mismatch", 32'(mismatch), 32'd0);
        chk("t5_readback", 32'(readback), 32'd0);
        xfer("t5a", 16'($urandom), 1'b0, 1'b1, 1'b0);
        chk("t5a_mm_const", 32'(mismatch), 32'd0);
        xfer("t5b", 16'($urandom), 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        n6 = 0;
        r6 = 0;
        while (busy6 === 1'b1 && n6 < 200) begin
            n6++;
            r6 += int'(reset6);
            @(negedge clk);
        end
        chk("t6_busy_len", 32'(n6), 32'd33);
        chk("t6_reset_cnt", 32'(r6), 32'd0);
        chk("t6_done", 32'(done6), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_config_engine.md
Name: serial_config_engine

Overview:
- Parametrised successor to the fixed 13x8-bit chip-configuration shifter.
- Takes a flat vector of NUM_REGS x REG_W configuration bits and serialises it to the chip's configuration chain on p_sck/p_sda.
- Frames the transfer with an optional chain-reset pulse (p_reset) and a capture strobe (p_scapt).
- Shifts the chain's previous contents back in on sdo_in so that an upset in the stored configuration is flagged as a mismatch.

Parameters:
- NUM_REGS, 12: number of configuration registers.
- REG_W, 8: bits per register.
- CLK_DIV, 4: clkin cycles per p_sck half-period (>=1).
- RST_CYC, 4: clkin cycles p_reset is held high (>=1).
- CAPT_CYC, 2: clkin cycles p_scapt is held high (>=1).
- AUTO_START, 1: 1 = a change of cfg_data while idle triggers programming without a start pulse.

Ports:
- clkin  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle programming request
- reset_en  in  1  1 = include the p_reset phase; 0 = skip it (scrub/readback mode)
- cfg_data  in  NUM_REGS*REG_W  configuration; register k occupies bits [k*REG_W +: REG_W]
- sdo_in  in  1  chain serial output from the chip (readback)
- p_sck  out  1  chain shift clock, active high
- p_sda  out  1  chain serial data
- p_scapt  out  1  chain capture strobe
- p_reset  out  1  chain reset
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse at the end of a transfer
- readback  out  NUM_REGS*REG_W  bits shifted out of the chain during the last transfer
- mismatch  out  1  readback differed from the previously programmed snapshot

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, readback=0, snapshot=0, prev_valid=0, FSM=IDLE.
- The mid-transfer reset condition is the same: immediate abort, all outputs forced low.
- FSM states and order: IDLE -> RESET -> SHIFT_LO -> SHIFT_HI (repeat per bit) -> CAPTURE -> FIN -> IDLE.
- RESET is skipped when reset_en=0 at the trigger; the FSM goes directly to the first SHIFT_LO.
- Trigger, sampled in IDLE only:
  - start=1, or
  - AUTO_START=1 and cfg_data != snapshot.
  - start while busy is ignored and not queued.
  - An auto-start difference that is still present after FIN retriggers.
- On the trigger cycle:
  - cfg_data is latched into shift register sr and into the new-snapshot register.
  - reset_en is latched.
  - busy=1 from the next cycle.
- RESET: p_reset=1 for exactly RST_CYC cycles; p_sck=0, p_sda=0.
- Bit count and order: N=NUM_REGS*REG_W bits, MSB first; first bit is cfg_data[N-1], last bit is cfg_data[0].
- SHIFT_LO: p_sda takes the current bit on the first cycle; p_sck=0 for CLK_DIV cycles.
- SHIFT_HI: p_sck=1 for CLK_DIV cycles.
  - sdo_in is sampled on the first SHIFT_HI cycle and shifted into readback at the LSB.
  - After N bits, readback[N-1] holds the first bit received.
- p_sda is stable throughout each low+high pair; it returns to 0 after the last SHIFT_HI.
- CAPTURE: p_scapt=1 for CAPT_CYC cycles; p_sck=0.
- FIN (one cycle):
  - done=1, busy=0.
  - mismatch = prev_valid & ~latched_reset_en & (readback != old snapshot); otherwise 0.
  - snapshot <= new snapshot; prev_valid <= 1.
  - mismatch holds until the next FIN or reset.
- Timing: busy lasts exactly RST_CYC*reset_en + 2*CLK_DIV*N + CAPT_CYC cycles. No gap cycles between phases.
- Counters: the bit counter is sized to clog2(N+1); the divider counter to clog2(CLK_DIV+1).
- Exclusivity: p_sck, p_reset and p_scapt are never high in the same cycle.
- cfg_data changes during busy do not affect the transfer in flight.

Test Plan:
1. NUM_REGS=2, REG_W=8, CLK_DIV=2, reset_en=1, cfg_data=16'hA5C3, start pulse:
   - p_reset high 4 cycles, then 16 p_sck pulses (2 low/2 high) with p_sda sequence 1010010111000011, then p_scapt high 2 cycles.
   - done asserts at busy-cycle 4+64+2=70; mismatch=0.
2. Loopback sdo_in to a 16-bit chip model:
   - program 16'h1234 (reset_en=1), then start with reset_en=0 and the same data -> readback=16'h1234, mismatch=0.
   - flip one model bit between transfers -> readback=16'h1236 (bit 1 flipped), mismatch=1.
3. AUTO_START=1, idle, change cfg_data 16'h0000->16'h00FF:
   - transfer begins the cycle after the change with no start pulse.
   - changing cfg_data again mid-transfer produces one further transfer after done.
4. Assert start on every cycle during busy -> exactly one transfer, exactly one done pulse.
5. rst_n low at bit 7 of SHIFT_HI -> p_sck, p_sda, busy drop immediately.
   - after release: idle, mismatch=0, prev_valid=0; the next start re-runs the full sequence.
6. CLK_DIV=1, RST_CYC=1, CAPT_CYC=1, reset_en=0 -> busy exactly 2*16+1=33 cycles, p_reset never asserted.
